// File: rtl/fir_interpolator_if.sv
// fir_interpolator_if
//  Bundles the sample-rate input stream, the fast-rate output stream and the
//  coefficient-load port of fir_interpolator into a single interface.
//  Ports / signals:
//   in_valid / in_ready / in_data     input sample handshake (16-bit signed)
//   out_valid / out_ready / out_data  interpolated output handshake (16-bit signed)
//   coef_we / coef_addr / coef_data   coefficient table write port
//  Modports:
//   master  environment side (drives samples, coefficients and out_ready)
//   slave   filter side (drives in_ready, out_valid and out_data)
interface fir_interpolator_if #(
  parameter int TAPS = 16
);
  localparam int AW = $clog2(TAPS);

  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               coef_we;
  logic [AW-1:0]      coef_addr;
  logic signed [15:0] coef_data;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_interpolator.sv
// fir_interpolator
//  Polyphase FIR interpolator: each accepted 16-bit signed input sample produces
//  L output samples (zero-stuff + lowpass). One multiply-accumulate is shared
//  across the PH = TAPS/L taps of each phase. The coefficient table is loadable
//  while the block is idle.
//  Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   fir_interpolator_if.slave (input stream, output stream, coef port)
//   busy  high whenever the block is not idle
module fir_interpolator #(
  parameter int TAPS       = 16,
  parameter int L          = 4,
  parameter int COEF_SHIFT = 14
) (
  input  logic              clk,
  input  logic              rst,
  fir_interpolator_if.slave bus,
  output logic              busy
);

  localparam int PH   = TAPS / L;
  localparam int AW   = $clog2(TAPS);
  localparam int KW   = (PH > 1) ? $clog2(PH) : 1;
  localparam int PW   = (L > 1) ? $clog2(L) : 1;
  localparam int ACCW = 32 + $clog2(PH) + 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_next;

  logic signed [15:0]     dl [PH];
  logic signed [15:0]     h  [TAPS];
  logic [PW-1:0]          phase;
  logic [KW-1:0]          k;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_sum;
  logic signed [ACCW-1:0] acc_shift;
  logic signed [31:0]     prod;
  logic [AW-1:0]          tap_idx;
  logic                   last_tap;
  logic                   last_phase;
  logic                   in_fire;
  logic                   out_fire;
  logic                   out_valid_q;
  logic signed [15:0]     out_data_q;
  logic signed [15:0]     sat_data;

  assign bus.in_ready  = (state == IDLE);
  assign busy          = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  assign last_tap   = (k == KW'(PH - 1));
  assign last_phase = (phase == PW'(L - 1));
  assign in_fire    = (state == IDLE) && bus.in_valid;
  assign out_fire   = (state == OUT) && out_valid_q && bus.out_ready;

  // Tap k of phase p uses prototype coefficient h[k*L+p]. acc_sum already
  // includes the current product so the final tap can be saturated and
  // registered into out_data on the same edge that enters OUT.
  always_comb begin
    tap_idx   = AW'(int'(k) * L + int'(phase));
    prod      = 32'(dl[k]) * 32'(h[tap_idx]);
    acc_sum   = acc + ACCW'(prod);
    acc_shift = acc_sum >>> COEF_SHIFT;
    if (acc_shift > ACCW'(32767))
      sat_data = 16'sd32767;
    else if (acc_shift < ACCW'(-32768))
      sat_data = -16'sd32768;
    else
      sat_data = acc_shift[15:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic: one MAC pass per phase, one OUT handshake per phase.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_fire) state_next = MAC;
      MAC:  if (last_tap) state_next = OUT;
      OUT:  if (out_fire) state_next = last_phase ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: delay line, coefficient table, tap/phase counters, accumulator
  // and the registered output. Coefficient writes are only honoured in IDLE so
  // the table never changes underneath a sample being filtered.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PH; i++) dl[i] <= '0;
      for (int j = 0; j < TAPS; j++) h[j] <= (j < L) ? 16'(1 << COEF_SHIFT) : '0;
      phase       <= '0;
      k           <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.coef_we) h[bus.coef_addr] <= bus.coef_data;
          if (in_fire) begin
            for (int i = PH - 1; i > 0; i--) dl[i] <= dl[i-1];
            dl[0] <= bus.in_data;
            phase <= '0;
            k     <= '0;
            acc   <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          if (last_tap) begin
            k           <= '0;
            out_data_q  <= sat_data;
            out_valid_q <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            if (!last_phase) begin
              phase <= phase + 1'b1;
              k     <= '0;
              acc   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
